// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV64 multi-cycle controller: opcodes, FSM state
// codes, ALU operand/operation selects, error codes and the decode bundle.
package rv_ctrl_pkg;

    // Major opcodes handled by the controller (IR[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Error codes reported on err_o
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Branch funct3 values that can be taken
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Instruction class flags produced by the opcode decoder
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_op;
        logic is_opimm;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/rv_ctrl_dec.sv
// Opcode classifier for the multi-cycle controller. Pure combinational:
// exactly one flag of the returned bundle is set for every opcode.
import rv_ctrl_pkg::*;

module rv_ctrl_dec (
    input  logic [6:0] opcode_i,
    output dec_t       dec_o
);

    // Map the major opcode onto one instruction class; anything else is illegal
    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OPC_LOAD:   dec_o.is_load   = 1'b1;
            OPC_STORE:  dec_o.is_store  = 1'b1;
            OPC_BRANCH: dec_o.is_branch = 1'b1;
            OPC_OP:     dec_o.is_op     = 1'b1;
            OPC_OPIMM:  dec_o.is_opimm  = 1'b1;
            default:    dec_o.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle main controller for the RV64 core: sequences FETCH, DECODE,
// EXEC, MEM and WB over the shared datapath, owns the memory handshake and
// halts on illegal opcodes or a memory request left unacknowledged too long.
// Optional build macro RV_CTRL_INSTRET_EN adds the retired-instruction
// counter; without it instret_o is tied to zero.
import rv_ctrl_pkg::*;

module rv_mc_ctrl #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic            zero_i,
    input  logic            mem_ack_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            addr_sel_o,
    output logic            ir_we_o,
    output logic            mdr_we_o,
    output logic            pc_we_o,
    output logic            pc_src_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic            aout_we_o,
    output logic            reg_we_o,
    output logic            wb_sel_o,
    output logic            halt_o,
    output logic [1:0]      err_o,
    output logic [XLEN-1:0] instret_o
);

    // Number of consecutive unacknowledged request cycles that triggers the bus-error halt
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [2:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] err_q, err_d;
    logic [7:0] wait_inc;
    logic       br_taken;
    logic       retire;
    dec_t       dec;

    rv_ctrl_dec u_dec (
        .opcode_i (opcode_i),
        .dec_o    (dec)
    );

    assign wait_inc = wait_cnt_q + 8'd1;
    assign br_taken = ((funct3_i == F3_BEQ) &&  zero_i) ||
                      ((funct3_i == F3_BNE) && !zero_i);

    // Next state, bus-wait counter, error capture and retire pulse
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wait_cnt_d = '0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ack_i) begin
                    state_d = ST_DECODE;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_load || dec.is_store) begin
                    state_d = ST_MEM;
                end else if (dec.is_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (dec.is_op || dec.is_opimm) begin
                    state_d = ST_WB;
                end else begin
                    // IR changed under us; treat like an illegal decode
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    if (dec.is_store) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Datapath control outputs: Moore from state, plus ack-qualified and branch-qualified strobes
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_we_o     = 1'b0;
        mdr_we_o    = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_ADD;
        aout_we_o   = 1'b0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_we_o     = mem_ack_i;
                pc_we_o     = mem_ack_i;
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM;
                aout_we_o   = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a_o = 1'b1;
                if (dec.is_branch) begin
                    alu_op_o = ALUOP_SUB;
                    pc_we_o  = br_taken;
                    pc_src_o = br_taken;
                end else if (dec.is_op) begin
                    alu_op_o  = ALUOP_FUNCT;
                    aout_we_o = 1'b1;
                end else if (dec.is_opimm) begin
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALUOP_FUNCT;
                    aout_we_o   = 1'b1;
                end else if (dec.is_load || dec.is_store) begin
                    alu_src_b_o = SRCB_IMM;
                    aout_we_o   = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = dec.is_store;
                mdr_we_o   = dec.is_load && mem_ack_i;
            end
            ST_WB: begin
                reg_we_o = 1'b1;
                wb_sel_o = dec.is_load;
            end
            default: ;
        endcase
    end

    assign halt_o = (state_q == ST_HALT);
    assign err_o  = err_q;

`ifdef RV_CTRL_INSTRET_EN
    logic [XLEN-1:0] instret_q;

    // Retired-instruction counter, wraps naturally at 2^XLEN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret_o = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret_o     = '0;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a phase-level model.
module tb_rv_mc_ctrl;

    localparam int XLEN = 64;

    // Model phases and instruction classes
    localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
    localparam int C_LD = 0, C_ST = 1, C_BR = 2, C_OP = 3, C_OPI = 4, C_ILL = 5;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [6:0]      opcode_i = 7'h13;
    logic [2:0]      funct3_i = 3'd0;
    logic            zero_i = 1'b0;
    logic            mem_ack_i = 1'b0;
    logic            mem_req_o, mem_we_o, addr_sel_o, ir_we_o, mdr_we_o;
    logic            pc_we_o, pc_src_o, alu_src_a_o, aout_we_o, reg_we_o, wb_sel_o, halt_o;
    logic [1:0]      alu_src_b_o, alu_op_o, err_o;
    logic [XLEN-1:0] instret_o;

    int              checks = 0;
    int              errors = 0;
    logic [XLEN-1:0] exp_instret = '0;
    logic [1:0]      exp_err = 2'b00;

    rv_mc_ctrl #(.XLEN(XLEN), .MAX_WAIT(15)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .zero_i      (zero_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .addr_sel_o  (addr_sel_o),
        .ir_we_o     (ir_we_o),
        .mdr_we_o    (mdr_we_o),
        .pc_we_o     (pc_we_o),
        .pc_src_o    (pc_src_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .aout_we_o   (aout_we_o),
        .reg_we_o    (reg_we_o),
        .wb_sel_o    (wb_sel_o),
        .halt_o      (halt_o),
        .err_o       (err_o),
        .instret_o   (instret_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] opc(input int c);
        case (c)
            C_LD:    return 7'b0000011;
            C_ST:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_OP:    return 7'b0110011;
            C_OPI:   return 7'b0010011;
            default: return 7'h7F;
        endcase
    endfunction

    // Observed control word: {req,we,asel,irwe,mdrwe,pcwe,pcsrc,srca,srcb[1:0],op[1:0],aoutwe,regwe,wbsel,halt}
    function automatic logic [15:0] obs_vec();
        return {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, mdr_we_o, pc_we_o, pc_src_o,
                alu_src_a_o, alu_src_b_o, alu_op_o, aout_we_o, reg_we_o, wb_sel_o, halt_o};
    endfunction

    // Expected control word for a phase, taken from the controller's behaviour table
    function automatic logic [15:0] exp_vec(input int ph, input int c, input logic [2:0] f3,
                                            input logic z, input logic ack);
        logic mreq, mwe, asel, irwe, mdrwe, pcwe, pcsrc, srca, aoutwe, regwe, wbsel, hlt;
        logic [1:0] srcb, op;
        {mreq, mwe, asel, irwe, mdrwe, pcwe, pcsrc, srca, aoutwe, regwe, wbsel, hlt} = '0;
        srcb = 2'b00;
        op   = 2'b00;
        case (ph)
            P_FETCH: begin
                mreq = 1'b1; srcb = 2'b01;
                irwe = ack;  pcwe = ack;
            end
            P_DEC: begin
                srcb = 2'b10; aoutwe = 1'b1;
            end
            P_EXEC: begin
                srca = 1'b1;
                if (c == C_BR) begin
                    op    = 2'b01;
                    pcwe  = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
                    pcsrc = pcwe;
                end else begin
                    aoutwe = 1'b1;
                    srcb   = (c == C_OP) ? 2'b00 : 2'b10;
                    op     = (c == C_OP || c == C_OPI) ? 2'b10 : 2'b00;
                end
            end
            P_MEM: begin
                mreq = 1'b1; asel = 1'b1;
                mwe   = (c == C_ST);
                mdrwe = (c == C_LD) && ack;
            end
            P_WB: begin
                regwe = 1'b1; wbsel = (c == C_LD);
            end
            default: hlt = 1'b1;
        endcase
        return {mreq, mwe, asel, irwe, mdrwe, pcwe, pcsrc, srca, srcb, op, aoutwe, regwe, wbsel, hlt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the model: drive ack/zero, check after settling, advance model on retire
    task automatic cyc(input int ph, input int c, input logic ack, input logic z, input string tag);
        @(negedge clk_i);
        mem_ack_i = ack;
        zero_i    = z;
        #1;
        chk({tag, "/ctl"}, 64'(obs_vec()), 64'(exp_vec(ph, c, funct3_i, z, ack)));
        chk({tag, "/err"}, 64'(err_o), 64'(exp_err));
`ifdef RV_CTRL_INSTRET_EN
        chk({tag, "/instret"}, 64'(instret_o), 64'(exp_instret));
`else
        chk({tag, "/instret"}, 64'(instret_o), 64'd0);
`endif
        if ((ph == P_EXEC && c == C_BR) || (ph == P_MEM && c == C_ST && ack) || ph == P_WB)
            exp_instret++;
        @(posedge clk_i);
        #1;
    endtask

    // Whole instruction: fd / md unacked cycles in FETCH / MEM before the ack
    task automatic run_instr(input int c, input logic [2:0] f3, input logic z,
                             input int fd, input int md, input string tag);
        opcode_i = opc(c);
        funct3_i = f3;
        for (int i = 0; i < fd; i++) cyc(P_FETCH, c, 1'b0, z, {tag, "/fetchwait"});
        cyc(P_FETCH, c, 1'b1, z, {tag, "/fetch"});
        cyc(P_DEC, c, 1'($urandom_range(0, 1)), z, {tag, "/dec"});
        cyc(P_EXEC, c, 1'($urandom_range(0, 1)), z, {tag, "/exec"});
        if (c == C_LD || c == C_ST) begin
            for (int i = 0; i < md; i++) cyc(P_MEM, c, 1'b0, z, {tag, "/memwait"});
            cyc(P_MEM, c, 1'b1, z, {tag, "/mem"});
        end
        if (c == C_LD || c == C_OP || c == C_OPI)
            cyc(P_WB, c, 1'($urandom_range(0, 1)), z, {tag, "/wb"});
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        mem_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        exp_instret = '0;
        exp_err     = 2'b00;
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // First cycle after reset (waits one cycle), then ld with immediate acks
        run_instr(C_OP, 3'd0, 1'b0, 1, 0, "first_op");
        run_instr(C_LD, 3'd3, 1'b0, 0, 0, "ld");
        // Store with ack delayed three cycles in MEM
        run_instr(C_ST, 3'd3, 1'b0, 0, 3, "sd_slow");
        // Branches: beq / bne, taken and not taken, plus an unsupported funct3
        run_instr(C_BR, 3'd0, 1'b1, 0, 0, "beq_t");
        run_instr(C_BR, 3'd0, 1'b0, 0, 0, "beq_nt");
        run_instr(C_BR, 3'd1, 1'b0, 0, 0, "bne_t");
        run_instr(C_BR, 3'd1, 1'b1, 0, 0, "bne_nt");
        run_instr(C_BR, 3'd4, 1'b1, 0, 0, "blt_nt");
        run_instr(C_OPI, 3'd0, 1'b0, 2, 0, "addi");

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            c = int'($urandom_range(0, 4));
            run_instr(c, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), "rand");
        end

        // Reset in the middle of a stalled store
        opcode_i = opc(C_ST);
        funct3_i = 3'd3;
        cyc(P_FETCH, C_ST, 1'b1, 1'b0, "rstmem/fetch");
        cyc(P_DEC, C_ST, 1'b0, 1'b0, "rstmem/dec");
        cyc(P_EXEC, C_ST, 1'b0, 1'b0, "rstmem/exec");
        cyc(P_MEM, C_ST, 1'b0, 1'b0, "rstmem/mem1");
        cyc(P_MEM, C_ST, 1'b0, 1'b0, "rstmem/mem2");
        do_reset();
        // Back in FETCH with req, no write; 14 waits then ack on the limit cycle proceeds
        run_instr(C_ST, 3'd3, 1'b0, 14, 0, "after_rst");

        // Fetch timeout: 15 unacked cycles then HALT with bus error; late acks ignored
        opcode_i = opc(C_OP);
        for (int i = 0; i < 15; i++) cyc(P_FETCH, C_OP, 1'b0, 1'b0, "tmo/fetch");
        exp_err = 2'b10;
        for (int i = 0; i < 3; i++) cyc(P_HALT, C_OP, 1'b1, 1'b0, "tmo/halt");
        do_reset();
        run_instr(C_OP, 3'd0, 1'b0, 0, 0, "tmo/recover");

        // Illegal opcode: DECODE goes to HALT with err 01; acks ignored; reset recovers
        opcode_i = opc(C_ILL);
        cyc(P_FETCH, C_ILL, 1'b1, 1'b0, "ill/fetch");
        cyc(P_DEC, C_ILL, 1'b0, 1'b0, "ill/dec");
        exp_err = 2'b01;
        for (int i = 0; i < 3; i++) cyc(P_HALT, C_ILL, 1'b1, 1'b0, "ill/halt");
        do_reset();
        run_instr(C_LD, 3'd3, 1'b0, 1, 2, "ill/recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
